// File: rtl/noc_pkg.sv
// Shared NoC definitions: virtual-channel identities, default link geometry,
// and an index-width helper used by the link scheduler and router.
package noc_pkg;

  typedef enum logic [1:0] {
    VC_REQUEST   = 2'd0,
    VC_RESPONSE  = 2'd1,
    VC_COHERENCE = 2'd2
  } vc_id_e;

  localparam int FLIT_WIDTH_DEF   = 128;
  localparam int VC_COUNT_DEF     = 3;
  localparam int CREDIT_DEPTH_DEF = 4;

  // Width of an index into n items; a single item still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// wrapping modulo N; the caller owns the pointer register.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req,
  input  logic [idx_width(N)-1:0]   ptr,
  output logic [N-1:0]              gnt,
  output logic [idx_width(N)-1:0]   gnt_idx,
  output logic                      any_gnt
);

  localparam int IW = idx_width(N);

  always_comb begin
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ni_vc_link_scheduler.sv
// Credit-based VC scheduler onto one router link: round-robin over VCs with a flit and a credit,
// one registered flit per cycle (1-cycle latency); no link backpressure, only per-VC credits.
module ni_vc_link_scheduler
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH   = FLIT_WIDTH_DEF,
  parameter int VC_COUNT     = VC_COUNT_DEF,
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 sched_en,
  input  logic [VC_COUNT-1:0][FLIT_WIDTH-1:0]  vc_flit_in,
  input  logic [VC_COUNT-1:0]                  vc_valid_in,
  output logic [VC_COUNT-1:0]                  vc_ready_out,
  output logic [FLIT_WIDTH-1:0]                link_flit_out,
  output logic [idx_width(VC_COUNT)-1:0]       link_vc_out,
  output logic                                 link_valid_out,
  input  logic [VC_COUNT-1:0]                  credit_return_in,
  output logic [VC_COUNT-1:0]                  credit_avail_out,
  output logic                                 err_credit_ovf
);

  localparam int              CW   = idx_width(VC_COUNT);
  localparam int              NW   = $clog2(CREDIT_DEPTH + 1);
  localparam logic [NW-1:0]   FULL = NW'(CREDIT_DEPTH);

  logic [NW-1:0]       credit [VC_COUNT];
  logic [VC_COUNT-1:0] has_credit;
  logic [VC_COUNT-1:0] eligible;
  logic [VC_COUNT-1:0] gnt;
  logic [CW-1:0]       ptr;
  logic [CW-1:0]       gnt_idx;
  logic                any_gnt;

  always_comb begin
    has_credit = '0;
    for (int i = 0; i < VC_COUNT; i++) begin
      has_credit[i] = (credit[i] != '0);
    end
  end

  // Eligibility uses registered counts, so a return this cycle only helps next cycle.
  assign eligible         = vc_valid_in & has_credit & {VC_COUNT{sched_en}};
  assign vc_ready_out     = gnt;
  assign credit_avail_out = has_credit;

  rr_arbiter #(
    .N (VC_COUNT)
  ) u_arb (
    .req     (eligible),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // A grant only happens with a nonzero count, so the decrement cannot underflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < VC_COUNT; i++) begin
        credit[i] <= FULL;
      end
      err_credit_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < VC_COUNT; i++) begin
        case ({gnt[i], credit_return_in[i]})
          2'b10: credit[i] <= credit[i] - 1'b1;
          2'b01: begin
            if (credit[i] == FULL) begin
              err_credit_ovf <= 1'b1;
            end else begin
              credit[i] <= credit[i] + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr            <= '0;
      link_flit_out  <= '0;
      link_vc_out    <= '0;
      link_valid_out <= 1'b0;
    end else begin
      link_valid_out <= any_gnt;
      if (any_gnt) begin
        ptr           <= (gnt_idx == CW'(VC_COUNT - 1)) ? '0 : gnt_idx + 1'b1;
        link_flit_out <= vc_flit_in[gnt_idx];
        link_vc_out   <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_ni_vc_link_scheduler.sv
// Bench for ni_vc_link_scheduler: table vectors plus corner sequences, checked against
// a behavioural credit/round-robin model with a scoreboard of in-flight link flits.
module tb_ni_vc_link_scheduler;
  import noc_pkg::*;

  localparam int FW = 128;
  localparam int NV = 3;
  localparam int CD = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              sched_en;
  logic [NV-1:0][FW-1:0] flits;
  logic [NV-1:0]     vc_valid_in;
  logic [NV-1:0]     vc_ready_out;
  logic [FW-1:0]     link_flit_out;
  logic [1:0]        link_vc_out;
  logic              link_valid_out;
  logic [NV-1:0]     credit_return_in;
  logic [NV-1:0]     credit_avail_out;
  logic              err_credit_ovf;

  always #5 clk = ~clk;

  ni_vc_link_scheduler #(
    .FLIT_WIDTH   (FW),
    .VC_COUNT     (NV),
    .CREDIT_DEPTH (CD)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sched_en         (sched_en),
    .vc_flit_in       (flits),
    .vc_valid_in      (vc_valid_in),
    .vc_ready_out     (vc_ready_out),
    .link_flit_out    (link_flit_out),
    .link_vc_out      (link_vc_out),
    .link_valid_out   (link_valid_out),
    .credit_return_in (credit_return_in),
    .credit_avail_out (credit_avail_out),
    .err_credit_ovf   (err_credit_ovf)
  );

  typedef struct {
    logic [FW-1:0] flit;
    int            vc;
  } exp_t;

  typedef struct {
    logic [2:0] v;
    logic [2:0] r;
    logic       en;
    logic [2:0] exp_rdy;
    logic [2:0] exp_avail;
  } vec_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   m_cred[NV];
  int   m_ptr;
  bit   m_ovf;
  bit   m_lv;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    foreach (m_cred[i]) m_cred[i] = CD;
    m_ptr = 0;
    m_ovf = 1'b0;
    m_lv  = 1'b0;
    sb.delete();
  endtask

  task automatic rand_flits();
    for (int i = 0; i < NV; i++) flits[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " ready"},  vc_ready_out, 0);
    chk({tag, " flit"},   link_flit_out, 0);
    chk({tag, " vc"},     link_vc_out, 0);
    chk({tag, " valid"},  link_valid_out, 0);
    chk({tag, " avail"},  credit_avail_out, 3'b111);
    chk({tag, " err"},    err_credit_ovf, 0);
  endtask

  task automatic do_reset(input string tag);
    reset_n          = 1'b0;
    vc_valid_in      = '0;
    credit_return_in = '0;
    sched_en         = 1'b1;
    @(negedge clk);
    chk_reset_values(tag);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // Entered 1 time unit after a rising edge; drives, checks at the falling edge, steps the model.
  task automatic cycle(input logic [2:0] v, input logic [2:0] r, input logic en,
                       input logic [2:0] hand_rdy, input bit use_hand, input string tag);
    int         g;
    int         idx;
    logic [2:0] exp_rdy;
    logic [2:0] exp_av;
    exp_t       e;
    vc_valid_in      = v;
    credit_return_in = r;
    sched_en         = en;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NV; k++) begin
      idx = (m_ptr + k) % NV;
      if (g < 0 && v[idx] && en && m_cred[idx] > 0) g = idx;
    end
    exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
    for (int i = 0; i < NV; i++) exp_av[i] = (m_cred[i] > 0);
    chk({tag, " ready"}, vc_ready_out, exp_rdy);
    if (use_hand) chk({tag, " ready(table)"}, vc_ready_out, hand_rdy);
    chk({tag, " avail"}, credit_avail_out, exp_av);
    chk({tag, " err"}, err_credit_ovf, m_ovf);
    chk({tag, " link_valid"}, link_valid_out, m_lv);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " link_flit"}, link_flit_out, e.flit);
      chk({tag, " link_vc"}, link_vc_out, e.vc);
    end
    for (int i = 0; i < NV; i++) begin
      if (g == i && !r[i]) m_cred[i]--;
      else if (g != i && r[i]) begin
        if (m_cred[i] == CD) m_ovf = 1'b1;
        else m_cred[i]++;
      end
    end
    if (g >= 0) begin
      e.flit = flits[g];
      e.vc   = g;
      sb.push_back(e);
      m_ptr = (g + 1) % NV;
    end
    m_lv = (g >= 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[8];
    logic [2:0] prev;

    reset_n          = 1'b0;
    sched_en         = 1'b1;
    vc_valid_in      = '0;
    credit_return_in = '0;
    flits            = '0;
    model_reset();

    do_reset("reset");

    // Hand-derived sequence from reset: ptr 0, credits 4/4/4.
    tbl[0] = '{v: 3'b010, r: 3'b000, en: 1'b1, exp_rdy: 3'b010, exp_avail: 3'b111};
    tbl[1] = '{v: 3'b000, r: 3'b000, en: 1'b1, exp_rdy: 3'b000, exp_avail: 3'b111};
    tbl[2] = '{v: 3'b111, r: 3'b010, en: 1'b1, exp_rdy: 3'b100, exp_avail: 3'b111};
    tbl[3] = '{v: 3'b111, r: 3'b100, en: 1'b1, exp_rdy: 3'b001, exp_avail: 3'b111};
    tbl[4] = '{v: 3'b111, r: 3'b001, en: 1'b1, exp_rdy: 3'b010, exp_avail: 3'b111};
    tbl[5] = '{v: 3'b111, r: 3'b010, en: 1'b1, exp_rdy: 3'b100, exp_avail: 3'b111};
    tbl[6] = '{v: 3'b111, r: 3'b100, en: 1'b1, exp_rdy: 3'b001, exp_avail: 3'b111};
    tbl[7] = '{v: 3'b000, r: 3'b001, en: 1'b1, exp_rdy: 3'b000, exp_avail: 3'b111};
    for (int i = 0; i < 8; i++) begin
      rand_flits();
      if (i == 0) flits[VC_RESPONSE] = 128'hA5;
      cycle(tbl[i].v, tbl[i].r, tbl[i].en, tbl[i].exp_rdy, 1'b1, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d avail(table)", i), credit_avail_out, tbl[i].exp_avail);
    end

    // All VCs busy with a credit returned for each grant: strict 0,1,2 rotation.
    do_reset("reset2");
    prev = 3'b000;
    for (int k = 0; k < 9; k++) begin
      rand_flits();
      cycle(3'b111, prev, 1'b1, 3'(1 << (k % 3)), 1'b1, $sformatf("rr%0d", k));
      prev = 3'(1 << (k % 3));
    end
    cycle(3'b000, prev, 1'b1, 3'b000, 1'b1, "rr_drain");

    // VC0 alone: four flits, stall, one return releases exactly one more.
    do_reset("reset3");
    for (int k = 0; k < 6; k++) begin
      rand_flits();
      cycle(3'b001, 3'b000, 1'b1, (k < 4) ? 3'b001 : 3'b000, 1'b1, $sformatf("vc0_%0d", k));
    end
    chk("vc0 drained avail", credit_avail_out[0], 1'b0);
    cycle(3'b001, 3'b001, 1'b1, 3'b000, 1'b1, "vc0_return");
    rand_flits();
    cycle(3'b001, 3'b000, 1'b1, 3'b001, 1'b1, "vc0_resume");
    cycle(3'b001, 3'b000, 1'b1, 3'b000, 1'b1, "vc0_stall2");
    cycle(3'b000, 3'b000, 1'b1, 3'b000, 1'b1, "vc0_idle");

    // VC2 grant and return together at credit 2 leaves 2: two more grants then stall.
    do_reset("reset4");
    rand_flits();
    cycle(3'b100, 3'b000, 1'b1, 3'b100, 1'b1, "vc2_a");
    cycle(3'b100, 3'b000, 1'b1, 3'b100, 1'b1, "vc2_b");
    cycle(3'b100, 3'b100, 1'b1, 3'b100, 1'b1, "vc2_same");
    cycle(3'b100, 3'b000, 1'b1, 3'b100, 1'b1, "vc2_c");
    cycle(3'b100, 3'b000, 1'b1, 3'b100, 1'b1, "vc2_d");
    cycle(3'b100, 3'b000, 1'b1, 3'b000, 1'b1, "vc2_stall");
    cycle(3'b000, 3'b000, 1'b1, 3'b000, 1'b1, "vc2_idle");

    // Return into a full counter: sticky error, count saturated at 4.
    do_reset("reset5");
    cycle(3'b000, 3'b001, 1'b1, 3'b000, 1'b1, "ovf_pulse");
    chk("ovf set", err_credit_ovf, 1'b1);
    for (int k = 0; k < 5; k++) begin
      rand_flits();
      cycle(3'b001, 3'b000, 1'b1, (k < 4) ? 3'b001 : 3'b000, 1'b1, $sformatf("ovf_vc0_%0d", k));
    end
    cycle(3'b000, 3'b000, 1'b1, 3'b000, 1'b1, "ovf_idle");
    chk("ovf sticky", err_credit_ovf, 1'b1);
    do_reset("reset6");

    // sched_en low blocks grants; in-flight flit still delivered; returns still counted.
    rand_flits();
    cycle(3'b111, 3'b000, 1'b1, 3'b001, 1'b1, "en_a");
    cycle(3'b111, 3'b000, 1'b1, 3'b010, 1'b1, "en_b");
    cycle(3'b111, 3'b000, 1'b0, 3'b000, 1'b1, "dis_a");
    cycle(3'b111, 3'b001, 1'b0, 3'b000, 1'b1, "dis_b");
    cycle(3'b111, 3'b000, 1'b0, 3'b000, 1'b1, "dis_c");
    rand_flits();
    cycle(3'b111, 3'b000, 1'b1, 3'b100, 1'b1, "reen_a");
    cycle(3'b111, 3'b000, 1'b1, 3'b001, 1'b1, "reen_b");

    // Reset mid-burst with a flit in the output register.
    chk("pre_reset valid", link_valid_out, 1'b1);
    reset_n          = 1'b0;
    vc_valid_in      = '0;
    credit_return_in = '0;
    #1;
    chk_reset_values("midreset");
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rand_flits();
      cycle(3'b001, 3'b000, 1'b1, (k < 4) ? 3'b001 : 3'b000, 1'b1, $sformatf("post_%0d", k));
    end
    cycle(3'b000, 3'b000, 1'b1, 3'b000, 1'b1, "post_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ni_vc_link_scheduler.md
# ni_vc_link_scheduler

Credit-based virtual-channel scheduler between the network interface and its router port. Merges the per-VC flit streams (VC0 request, VC1 response, VC2 coherence) onto one physical link. Uses round-robin arbitration among VCs that have both a pending flit and a downstream credit. Tracks per-VC credits returned by the router.

## Interface

Parameters:
- FLIT_WIDTH, 128, flit width in bits
- VC_COUNT, 3, number of virtual channels
- CREDIT_DEPTH, 4, downstream buffer slots per VC (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- sched_en  in  1  grant enable; when low, no new grants are issued
- vc_flit_in  in  VC_COUNT×FLIT_WIDTH  flit per VC
- vc_valid_in  in  VC_COUNT  flit pending per VC
- vc_ready_out  out  VC_COUNT  one-hot grant; flit taken when valid&ready
- link_flit_out  out  FLIT_WIDTH  registered flit to router
- link_vc_out  out  CW=max(1,$clog2(VC_COUNT))  VC tag of link flit
- link_valid_out  out  1  link flit valid; no backpressure, credits only
- credit_return_in  in  VC_COUNT  one-cycle pulse per freed router slot
- credit_avail_out  out  VC_COUNT  bit i = credit count of VC i > 0
- err_credit_ovf  out  1  sticky; a credit was returned to a full counter

## Operation

- Credit counters: one per VC, width $clog2(CREDIT_DEPTH+1), reset to CREDIT_DEPTH.
  - Grant to VC i decrements it.
  - credit_return_in[i] increments it.
  - Both in the same cycle: count unchanged.
  - Return at CREDIT_DEPTH with no grant: count saturates and err_credit_ovf sets. It clears only on reset.
- Eligibility: eligible[i] = vc_valid_in[i] & (credit[i] != 0) & sched_en.
  - Credits returned this cycle do not count toward eligibility until the next cycle.
- Arbitration: round-robin over eligible VCs, searched from priority pointer ptr upward with wrap modulo VC_COUNT.
  - At most one grant per cycle.
  - vc_ready_out is combinational from vc_valid_in and registered state; it is zero when no VC is eligible.
  - After a grant to VC g, ptr ← (g+1) mod VC_COUNT. ptr is unchanged when there is no grant.
  - ptr resets to 0.
- Output register:
  - On a grant, the next edge loads link_flit_out ← vc_flit_in[g], link_vc_out ← g, link_valid_out ← 1.
  - With no grant, link_valid_out ← 0 and link_flit_out/link_vc_out hold their last values.
- Producer rule: a producer must hold flit and valid stable until accepted. The scheduler does not rely on this for correctness.
- sched_en low: no grants are issued and counters still accept returns. A flit already in the output register is still presented.
- Reset mid-operation: everything returns to reset values immediately, including any in-flight output flit. Upstream must reset together with the scheduler.

## Timing

- Reset values: vc_ready_out 0, link_flit_out 0, link_vc_out 0, link_valid_out 0, credit_avail_out all 1, err_credit_ovf 0.
- Latency: a flit accepted in cycle N is valid on the link in cycle N+1.
- Throughput: 1 flit/cycle sustained while any VC is eligible.
- A single VC with no returns sends exactly CREDIT_DEPTH back-to-back flits, then stalls. It resumes the cycle after a credit return.
- credit_avail_out is derived from registered counts and reflects a return one cycle later.

## Structure

- Shared package noc_pkg: VC_REQUEST=0, VC_RESPONSE=1, VC_COHERENCE=2, default FLIT_WIDTH, VC_COUNT, CREDIT_DEPTH.
- Sub-module rr_arbiter (parameter N), reused by the router:
  - inputs: req[N], ptr
  - outputs: one-hot gnt, encoded gnt_idx, any_gnt
- The top level holds the credit counters, ptr, output register and error flag.

## Test plan

- Reset, then VC1 valid with flit 0xA5 (others idle) → vc_ready_out=3'b010 that cycle; next cycle link_valid_out=1, link_vc_out=1, link_flit_out=0xA5; VC1 credit=3.
- All three VCs valid continuously, credits returned on every grant → grant order VC0,VC1,VC2,VC0,…; link_valid_out=1 every cycle.
- VC0 only, no returns → exactly 4 flits sent, then vc_ready_out=0 and credit_avail_out[0]=0; one credit_return_in[0] pulse → one more flit 2 cycles later.
- Grant and credit_return_in on VC2 in the same cycle at credit=2 → credit remains 2.
- credit_return_in[0] pulse at credit=4 → err_credit_ovf=1 next cycle, credit stays 4, flag persists until reset_n low.
- sched_en=0 with all VCs valid → no grants, link_valid_out drops after the in-flight flit; reset_n asserted mid-burst → all outputs at reset values immediately, credits back to 4.
